// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receive/transmit blocks.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = IDLE,
        StStart  = START,
        StData   = DATA,
        StParity = PARITY,
        StStop   = STOP
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Baud divisors for a 100 MHz clock with 16x oversampling
    localparam logic [15:0] DIV_9600   = 16'd651;
    localparam logic [15:0] DIV_115200 = 16'd54;
    localparam logic [15:0] DIV_921600 = 16'd7;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every max(baud_div,1) clocks, phase reset by clear.
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] baud_div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] term;
    logic             hit;

    // >= rather than == so a divisor shrinking mid-count cannot strand the counter
    always_comb begin
        term      = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
        hit       = (div_cnt_q >= term);
        tick_o    = hit && !clear_i;
        div_cnt_d = (clear_i || hit) ? '0 : div_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, 3-sample majority vote, parity/framing flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_input,
    input  logic [DIV_W-1:0]     baud_div,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned M    = OVERSAMPLE / 2;
    localparam int unsigned OsW  = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [OsW-1:0]       os_cnt_q, os_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 par_bad_q, par_bad_d;
    logic                 frame_bad_q, frame_bad_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 tick, vote, vote_tick, bit_end;

    // Held clear while idle so the bit phase starts at the detected falling edge
    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_baud_tick (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clear_i   (state_q == StIdle),
        .baud_div_i(baud_div),
        .tick_o    (tick)
    );

    assign vote      = maj3(samp_q[0], samp_q[1], rx_s_q);
    assign vote_tick = tick && (os_cnt_q == OsW'(M + 1));
    assign bit_end   = tick && (os_cnt_q == OsW'(OVERSAMPLE - 1));

    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        frame_bad_d = frame_bad_q;
        byte_d      = byte_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        valid_d     = 1'b0;

        if (tick) begin
            os_cnt_d = bit_end ? '0 : os_cnt_q + OsW'(1);
            if (os_cnt_q == OsW'(M - 1)) samp_d[0] = rx_s_q;
            if (os_cnt_q == OsW'(M))     samp_d[1] = rx_s_q;
        end

        unique case (state_q)
            StIdle: begin
                os_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d     = StStart;
                    par_bad_d   = 1'b0;
                    frame_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (vote_tick && vote) begin
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (vote_tick) shift_d[bit_cnt_q] = vote;
                if (bit_end) begin
                    if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
                        state_d    = (PARITY_EN != 0) ? StParity : StStop;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (vote_tick) par_bad_d = vote ^ (^shift_q) ^ (PARITY_ODD != 0);
                if (bit_end) begin
                    state_d    = StStop;
                    stop_cnt_d = 1'b0;
                end
            end
            StStop: begin
                if (vote_tick) begin
                    if (!vote) frame_bad_d = 1'b1;
                    // Leave at mid-bit of the last stop so back-to-back frames tolerate skew
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = StIdle;
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                        perr_d  = (PARITY_EN != 0) && par_bad_q;
                        ferr_d  = frame_bad_q | ~vote;
                    end
                end else if (bit_end) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            samp_q      <= '0;
            shift_q     <= '0;
            par_bad_q   <= 1'b0;
            frame_bad_q <= 1'b0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_input;
            rx_s_q      <= rx_meta_q;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            par_bad_q   <= par_bad_d;
            frame_bad_q <= frame_bad_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign byte_data  = byte_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receiver configurations fed by a bit-level line driver.
module tb_uart_rx_param;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        rx_line [3];
    logic [7:0]  bd      [3];
    logic        dv      [3];
    logic        pe      [3];
    logic        fe      [3];
    logic        bz      [3];

    // Receiver configurations: 0 = 8N1, 1 = 8E1, 2 = 8N2
    int par_en_c [3] = '{0, 1, 0};
    int stop_c   [3] = '{1, 1, 2};

    exp_t       exp_q[$];
    logic       stream[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         pulses   [3] = '{0, 0, 0};
    logic [7:0] hold_d   [3] = '{8'h00, 8'h00, 8'h00};
    logic       hold_pe  [3] = '{1'b0, 1'b0, 1'b0};
    logic       hold_fe  [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .DIV_W(16)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx_input(rx_line[0]), .baud_div(baud_div),
        .byte_data(bd[0]), .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]),
        .busy(bz[0])
    );

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .DIV_W(16)
    ) u_dut_p (
        .clk(clk), .rst_n(rst_n), .rx_input(rx_line[1]), .baud_div(baud_div),
        .byte_data(bd[1]), .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]),
        .busy(bz[1])
    );

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .DIV_W(16)
    ) u_dut_s (
        .clk(clk), .rst_n(rst_n), .rx_input(rx_line[2]), .baud_div(baud_div),
        .byte_data(bd[2]), .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]),
        .busy(bz[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Builds the line bits of one frame and predicts what a receiver must report for it
    task automatic append_frame(input int inst, input logic [7:0] data, input logic par_flip,
                                input logic [1:0] stop_v, input bit push, output exp_t e);
        logic bits[$];
        int   idx;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (par_en_c[inst] != 0) bits.push_back((^data) ^ par_flip);
        for (int s = 0; s < stop_c[inst]; s++) bits.push_back(stop_v[s]);
        e.inst = inst;
        for (int i = 0; i < 8; i++) e.d[i] = bits[1 + i];
        idx  = 9;
        e.pe = 1'b0;
        if (par_en_c[inst] != 0) begin
            e.pe = bits[idx] ^ (^e.d);
            idx++;
        end
        e.fe = 1'b0;
        for (int s = 0; s < stop_c[inst]; s++) if (!bits[idx + s]) e.fe = 1'b1;
        if (push) exp_q.push_back(e);
        foreach (bits[k]) stream.push_back(bits[k]);
    endtask

    // Bit n spans clocks [n*p100/100, (n+1)*p100/100); spike inverts one clock
    task automatic drive_stream(input int inst, input int p100, input int spike);
        int c = 0;
        int n_end;
        @(posedge clk);
        #1;
        for (int n = 0; n < stream.size(); n++) begin
            n_end = ((n + 1) * p100) / 100;
            while (c < n_end) begin
                rx_line[inst] = (c == spike) ? ~stream[n] : stream[n];
                @(posedge clk);
                #1;
                c++;
            end
        end
        rx_line[inst] = 1'b1;
        stream.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int run = 0;
        int k   = 0;
        while (run < 8 && k < budget) begin
            @(negedge clk);
            k++;
            if (!bz[0] && !bz[1] && !bz[2] && exp_q.size() == 0) run++;
            else run = 0;
        end
        check(name, 32'(run >= 8), 32'd1);
        if (run < 8) exp_q.delete();
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                hold_d[i]  = 8'h00;
                hold_pe[i] = 1'b0;
                hold_fe[i] = 1'b0;
            end else begin
                if (dv[i]) begin
                    pulses[i]++;
                    check($sformatf("busy_at_valid[%0d]", i), 32'(bz[i]), 32'd0);
                    check($sformatf("valid_expected[%0d]", i), 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("valid_inst[%0d]", i), i, e.inst);
                        hold_d[i]  = e.d;
                        hold_pe[i] = e.pe;
                        hold_fe[i] = e.fe;
                    end
                end
                check($sformatf("byte_data[%0d]", i), 32'(bd[i]), 32'(hold_d[i]));
                check($sformatf("parity_err[%0d]", i), 32'(pe[i]), 32'(hold_pe[i]));
                check($sformatf("frame_err[%0d]", i), 32'(fe[i]), 32'(hold_fe[i]));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        int   base;
        int   inst, nf, cpb, dsel;
        logic [1:0] stop_v;
        logic flip;

        rst_n    = 1'b0;
        baud_div = 16'd4;
        for (int i = 0; i < 3; i++) rx_line[i] = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_byte", 32'(bd[i]), 32'd0);
            check("reset_valid", 32'(dv[i]), 32'd0);
            check("reset_perr", 32'(pe[i]), 32'd0);
            check("reset_ferr", 32'(fe[i]), 32'd0);
            check("reset_busy", 32'(bz[i]), 32'd0);
        end

        // Basic 8N1 at 64 clk/bit
        append_frame(0, 8'hA5, 1'b0, 2'b11, 1'b1, e);
        check("model_a5", 32'(e.d), 32'hA5);
        drive_stream(0, 6400, -1);
        wait_idle("idle_basic", 2000);
        check("basic_byte", 32'(bd[0]), 32'hA5);
        check("basic_flags", 32'({pe[0], fe[0]}), 32'd0);
        check("basic_pulses", pulses[0], 1);

        // Glitch then false start
        @(posedge clk);
        #1 rx_line[0] = 1'b0;
        @(posedge clk);
        #1 rx_line[0] = 1'b1;
        wait_idle("idle_glitch", 500);
        rx_line[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx_line[0] = 1'b1;
        wait_idle("idle_false_start", 500);
        check("false_start_pulses", pulses[0], 1);
        append_frame(0, 8'h3C, 1'b0, 2'b11, 1'b1, e);
        drive_stream(0, 6400, -1);
        wait_idle("idle_3c", 2000);
        check("after_glitch_byte", 32'(bd[0]), 32'h3C);

        // Even parity
        append_frame(1, 8'h07, 1'b0, 2'b11, 1'b1, e);
        check("model_par_good", 32'(e.pe), 32'd0);
        drive_stream(1, 6400, -1);
        wait_idle("idle_par_good", 2000);
        check("par_good_perr", 32'(pe[1]), 32'd0);
        append_frame(1, 8'h07, 1'b1, 2'b11, 1'b1, e);
        check("model_par_bad", 32'(e.pe), 32'd1);
        drive_stream(1, 6400, -1);
        wait_idle("idle_par_bad", 2000);
        check("par_bad_perr", 32'(pe[1]), 32'd1);
        check("par_bad_byte", 32'(bd[1]), 32'h07);
        check("par_pulses", pulses[1], 2);

        // Framing: second stop low, then zero data with first stop low, then clean
        append_frame(2, 8'h96, 1'b0, 2'b01, 1'b1, e);
        check("model_stop2_low", 32'(e.fe), 32'd1);
        drive_stream(2, 6400, -1);
        wait_idle("idle_stop2", 2000);
        check("stop2_ferr", 32'(fe[2]), 32'd1);
        check("stop2_byte", 32'(bd[2]), 32'h96);
        append_frame(2, 8'h00, 1'b0, 2'b10, 1'b1, e);
        drive_stream(2, 6400, -1);
        wait_idle("idle_zero_break", 2000);
        check("zero_break_ferr", 32'(fe[2]), 32'd1);
        check("zero_break_byte", 32'(bd[2]), 32'h00);
        append_frame(2, 8'h3A, 1'b0, 2'b11, 1'b1, e);
        drive_stream(2, 6400, -1);
        wait_idle("idle_clean2", 2000);
        check("clean2_ferr", 32'(fe[2]), 32'd0);
        check("stop_pulses", pulses[2], 3);

        // One-clock spike mid data bit 2
        append_frame(0, 8'h5A, 1'b0, 2'b11, 1'b1, e);
        drive_stream(0, 6400, 3 * 64 + 37);
        wait_idle("idle_spike", 2000);
        check("spike_byte", 32'(bd[0]), 32'h5A);

        // Back-to-back, transmitter 2% slow, at three divisors
        for (int r = 0; r < 3; r++) begin
            baud_div = (r == 0) ? 16'd4 : (r == 1) ? 16'd1 : 16'd0;
            cpb      = (r == 0) ? 64 : 16;
            base     = pulses[0];
            append_frame(0, 8'h00, 1'b0, 2'b11, 1'b1, e);
            append_frame(0, 8'hFF, 1'b0, 2'b11, 1'b1, e);
            append_frame(0, 8'h55, 1'b0, 2'b11, 1'b1, e);
            drive_stream(0, cpb * 102, -1);
            wait_idle("idle_b2b", 3000);
            check("b2b_pulses", pulses[0] - base, 3);
            check("b2b_last_byte", 32'(bd[0]), 32'h55);
        end

        // Reset during data bit 3
        baud_div = 16'd4;
        base     = pulses[0];
        append_frame(0, 8'hF8, 1'b0, 2'b11, 1'b0, e);
        fork
            drive_stream(0, 6400, -1);
            begin
                repeat (4 * 64 + 30) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                check("midrst_byte", 32'(bd[0]), 32'd0);
                check("midrst_flags", 32'({dv[0], pe[0], fe[0]}), 32'd0);
                check("midrst_busy", 32'(bz[0]), 32'd0);
            end
        join
        wait_idle("idle_midrst", 2000);
        check("midrst_pulses", pulses[0] - base, 0);
        append_frame(0, 8'h81, 1'b0, 2'b11, 1'b1, e);
        drive_stream(0, 6400, -1);
        wait_idle("idle_81", 2000);
        check("after_rst_byte", 32'(bd[0]), 32'h81);

        // Randomised frames across configurations, divisors and rate skew
        for (int k = 0; k < 24; k++) begin
            inst     = $urandom_range(0, 2);
            dsel     = $urandom_range(0, 3);
            baud_div = (dsel == 3) ? 16'd4 : 16'(dsel);
            cpb      = 16 * ((baud_div == 0) ? 1 : int'(baud_div));
            nf       = $urandom_range(1, 2);
            for (int f = 0; f < nf; f++) begin
                flip   = (inst == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                stop_v = (inst == 2 && $urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
                append_frame(inst, 8'($urandom), flip, stop_v, 1'b1, e);
            end
            drive_stream(inst, cpb * (98 + $urandom_range(0, 4)), -1);
            wait_idle("idle_rand", 3000);
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
